// File: rtl/arb_rr_3_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_rr_3_pkg                                                     |
// | Shared FSM states and 3:1 datapath mux select codes.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package arb_rr_3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  function automatic logic [2:0] sel_to_onehot(input logic [1:0] s);
    logic [2:0] v;
    v = 3'b000;
    case (s)
      SEL_A:   v = 3'b001;
      SEL_B:   v = 3'b010;
      SEL_C:   v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_3_rr_pick3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick3                                                         |
// | Combinational round-robin pick among three requesters.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick3
  import arb_rr_3_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_winner,
  output logic       valid,
  output logic [1:0] winner
);

  // Search starts at the source after last_winner: a->b->c->a.
  always_comb begin
    valid  = |req;
    winner = SEL_A;
    case (last_winner)
      SEL_A: begin
        if (req[1])      winner = SEL_B;
        else if (req[2]) winner = SEL_C;
        else             winner = SEL_A;
      end
      SEL_B: begin
        if (req[2])      winner = SEL_C;
        else if (req[0]) winner = SEL_A;
        else             winner = SEL_B;
      end
      default: begin
        if (req[0])      winner = SEL_A;
        else if (req[1]) winner = SEL_B;
        else             winner = SEL_C;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arb_rr_3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arb_rr_3                                                         |
// | 3-source round-robin arbiter with hold timeout for a 3:1 mux.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module arb_rr_3
  import arb_rr_3_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_c,
  input  logic       done,
  output logic       grant_a,
  output logic       grant_b,
  output logic       grant_c,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int                 c_CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_HOLD - 1);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_sel;
  logic [2:0]         r_grant;
  logic               r_busy;
  logic               r_timeout;
  logic [1:0]         r_last;

  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]         w_sel_nxt;
  logic [2:0]         w_grant_nxt;
  logic               w_busy_nxt;
  logic               w_timeout_nxt;
  logic [1:0]         w_last_nxt;

  logic [2:0]         w_req;
  logic               w_valid;
  logic [1:0]         w_winner;
  logic               w_held;
  logic               w_at_limit;

  assign w_req      = {req_c, req_b, req_a};
  assign w_held     = |(w_req & r_grant);
  assign w_at_limit = (r_cnt == c_CNT_LAST);

  rr_pick3 u_pick (
    .req         (w_req),
    .last_winner (r_last),
    .valid       (w_valid),
    .winner      (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= SEL_A;
      r_grant   <= 3'b000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= SEL_C;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_last    <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_sel_nxt     = r_sel;
    w_grant_nxt   = r_grant;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_last_nxt    = r_last;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = 3'b000;
        w_busy_nxt  = 1'b0;
        if (w_valid) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_winner;
          w_grant_nxt = sel_to_onehot(w_winner);
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        // done beats the hold limit, and a dropped request is never a timeout.
        if (done || !w_held || w_at_limit) begin
          w_state_nxt   = ST_RELEASE;
          w_grant_nxt   = 3'b000;
          w_busy_nxt    = 1'b0;
          w_last_nxt    = r_sel;
          w_timeout_nxt = !done && w_held;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign grant_a = r_grant[0];
  assign grant_b = r_grant[1];
  assign grant_c = r_grant[2];
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_arb_rr_3                                                      |
// | Directed self-checking bench for arb_rr_3 (MAX_HOLD = 16).       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_arb_rr_3;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, req_c, done;
  logic       grant_a, grant_b, grant_c;
  logic [1:0] sel;
  logic       busy, timeout;
  logic [2:0] g;

  int n_cmp  = 0;
  int n_fail = 0;

  assign g = {grant_c, grant_b, grant_a};

  arb_rr_3 #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_c   (req_c),
    .done    (done),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .grant_c (grant_c),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, settle, and check the always-true output invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cmp++;
    if (!((g == 3'b000) || (g == 3'b001) || (g == 3'b010) || (g == 3'b100)) || sel == 2'd3 ||
        (busy && (g != (3'b001 << sel))) || (busy != (|g))) begin
      n_fail++;
      $display("FAIL invariant at %0t: grants=%b sel=%0d busy=%b required onehot0, sel!=3, sel matches grant",
               $time, g, sel, busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++;
    if ({g, sel, busy, timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: grants=%b sel=%0d busy=%b timeout=%b required all 0", g, sel, busy, timeout);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req_a = 1'b1;
    tick();
    n_cmp++;
    if (g !== 3'b001 || sel !== 2'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant: grants=%b sel=%0d busy=%b required 001/0/1", g, sel, busy);
    end
    done = 1'b1;
    tick();
    n_cmp++;
    if (g !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: grants=%b busy=%b timeout=%b required 000/0/0", g, busy, timeout);
    end
    done = 1'b0;
    req_a = 1'b0;
    tick();
    n_cmp++;
    if (g !== 3'b000 || busy !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_idle: grants=%b busy=%b sel=%0d required 000/0/0", g, busy, sel);
    end
  endtask

  task automatic test_rr_order();
    logic [1:0] ord [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      do begin
        tick();
        k++;
      end while (!busy && k < 6);
      n_cmp++;
      if (!busy || g !== (3'b001 << ord[i]) || sel !== ord[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: grants=%b sel=%0d busy=%b required grant sel %0d", i, g, sel, busy, ord[i]);
      end
      tick();
      n_cmp++;
      if (g !== (3'b001 << ord[i])) begin
        n_fail++;
        $display("FAIL rr_hold[%0d]: grants=%b required %b", i, g, 3'b001 << ord[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if (g !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_release[%0d]: grants=%b busy=%b timeout=%b required 000/0/0", i, g, busy, timeout);
      end
    end
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int len;
    do_reset();
    req_b = 1'b1;
    tick();
    len = 0;
    while (grant_b && len < 40) begin
      len++;
      tick();
    end
    n_cmp++;
    if (len != 16) begin
      n_fail++;
      $display("FAIL timeout_len: grant_b cycles=%0d required 16", len);
    end
    n_cmp++;
    if (timeout !== 1'b1 || g !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_pulse: timeout=%b grants=%b required 1/000", timeout, g);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || g !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_width: timeout=%b grants=%b required 0/000", timeout, g);
    end
    tick();
    n_cmp++;
    if (g !== 3'b010 || sel !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_regrant: grants=%b sel=%0d required 010/1", g, sel);
    end
    req_b = 1'b0;
    tick();
    n_cmp++;
    if (g !== 3'b000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL early_release: grants=%b timeout=%b required 000/0", g, timeout);
    end
    tick();
    tick();
    n_cmp++;
    if (sel !== 2'd1 || g !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_sel_hold: sel=%0d grants=%b required 1/000", sel, g);
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    req_a = 1'b1;
    tick();
    repeat (15) tick();
    n_cmp++;
    if (g !== 3'b001) begin
      n_fail++;
      $display("FAIL limit_hold: grants=%b required 001", g);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if (g !== 3'b000 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_wins: grants=%b timeout=%b busy=%b required 000/0/0", g, timeout, busy);
    end
    req_a = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_c = 1'b1;
    tick();
    n_cmp++;
    if (g !== 3'b100 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL c_grant: grants=%b sel=%0d required 100/2", g, sel);
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({g, sel, busy, timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: grants=%b sel=%0d busy=%b timeout=%b required all 0", g, sel, busy, timeout);
    end
    req_a = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (g !== 3'b000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: grants=%b timeout=%b required 000/0", g, timeout);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (g !== 3'b001 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_a_first: grants=%b sel=%0d required 001/0", g, sel);
    end
    req_a = 1'b0; req_c = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; done = 1'b0;
    test_reset();
    test_basic();
    test_rr_order();
    test_timeout();
    test_done_at_limit();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_rr_3.md
ARB_RR_3 -- requirements
Module: arb_rr_3

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, maximum grant length in cycles before forced release (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_a, req_b, req_c  input  1 each  requests from the three sources feeding the shared 3:1 datapath mux.
REQ-005 SHALL have port done  input  1  shared resource reports the current transfer complete.
REQ-006 SHALL have ports grant_a, grant_b, grant_c  output  1 each  registered grants, at most one high.
REQ-007 SHALL have port sel  output  2  registered mux select: 2'd0=a, 2'd1=b, 2'd2=c; 2'd3 never driven.
REQ-008 SHALL have port busy  output  1  high while in GRANT.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement states IDLE, GRANT, RELEASE; IDLE is the reset state.
REQ-011 In IDLE with any req high, SHALL choose the winner in round-robin order starting at the source after last_winner, enter GRANT next edge, assert that grant and set sel accordingly (1-cycle req-to-grant latency).
REQ-012 In IDLE with no req, SHALL stay in IDLE; grants low, sel holds its last value.
REQ-013 In GRANT, hold counter SHALL start at 0 on entry and increment each cycle; width clog2(MAX_HOLD+1).
REQ-014 In GRANT, done=1 SHALL move to RELEASE on the next edge without a timeout pulse.
REQ-015 In GRANT, the granted source dropping its req SHALL move to RELEASE on the next edge (early release, no timeout).
REQ-016 In GRANT, counter reaching MAX_HOLD-1 with done=0 SHALL move to RELEASE and pulse timeout for exactly the RELEASE cycle.
REQ-017 If done and counter==MAX_HOLD-1 coincide, done SHALL win: no timeout.
REQ-018 On leaving GRANT, last_winner SHALL update to the granted source; requests from non-granted sources SHALL be ignored during GRANT (no preemption).
REQ-019 RELEASE SHALL last exactly one cycle with all grants low, busy low, then return to IDLE; arbitration resumes the following cycle.
REQ-020 Pointer wrap: after c wins, a SHALL be first in priority; the round-robin order is a->b->c->a.
REQ-021 grant_* and sel SHALL change only on the same edge and SHALL never disagree.

Reset
REQ-022 rst high SHALL immediately force state=IDLE, all grants 0, sel=2'd0, busy=0, timeout=0, counter=0, last_winner=c (so a has first priority).
REQ-023 rst asserted mid-GRANT SHALL drop the grant asynchronously with no timeout pulse; first arbitration after rst deasserts starts from a.

Structure
REQ-024 State encodings and sel codes (SEL_A, SEL_B, SEL_C) SHALL live in a shared package/header used with the MUX_3_1 datapath.
REQ-025 Round-robin winner selection SHALL be a combinational sub-module rr_pick3 (inputs req[2:0], last_winner; outputs valid, winner).
REQ-026 Target size: 120-250 lines RTL plus sub-module.

Verification
REQ-027 Reset, then req_a=1 alone -> grant_a=1, sel=0, busy=1 one cycle later; done pulse -> RELEASE cycle with grants 0, then IDLE.
REQ-028 All three req held high, done pulsed 2 cycles into each grant -> grant order a, b, c, a with one idle/release gap between each.
REQ-029 req_b held, done never asserted, MAX_HOLD=16 -> grant_b high exactly 16 cycles, timeout pulse exactly 1 cycle, then b re-granted after IDLE if still requesting (after a/c checked).
REQ-030 done asserted on the cycle counter==MAX_HOLD-1 -> release with timeout=0.
REQ-031 rst pulsed mid-grant of c -> outputs zero immediately, no timeout; with req_a and req_c both high afterward, a wins first.
REQ-032 Throughout all tests assert: one-hot-or-zero grants, sel!=3, sel matches grant when busy.
